// File: rtl/div_iter.sv
// ----------------------------------------------------------------------------
// div_iter -- iterative radix-2 restoring divider (DIV/DIVU/REM/REMU)
//
// Accepts one divide op over a valid/ready handshake and produces the
// quotient and remainder after XLEN iterations plus one correction cycle.
// Results are held until the consumer takes them. A flush aborts any
// in-flight op and drops its result.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   flush       abort in-flight op, discard result
//   div_valid   request valid
//   div_ready   divider can accept a request (IDLE only)
//   div_signed  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
//   dividend    dividend operand
//   divisor     divisor operand
//   out_valid   result valid
//   out_ready   consumer accepts result
//   quotient    quotient result
//   remainder   remainder result
//
// Optional feature macro: DIV_EARLY_OUT_EN
//   When defined, divide-by-zero, signed overflow and |dividend| < |divisor|
//   skip the iterations and go straight from IDLE to DONE. Result values are
//   identical either way; only latency changes.
// ----------------------------------------------------------------------------
module div_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            div_valid,
  output logic            div_ready,
  input  logic            div_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_fin;       // all iterations done, next CALC edge corrects
  logic [XLEN-1:0] r_rem;       // upper half of the {rem,quo} partial register
  logic [XLEN-1:0] r_quo;       // lower half: dividend bits shift out, quotient bits in
  logic [XLEN-1:0] r_dsr_mag;
  logic [XLEN-1:0] r_dvd_raw;
  logic            r_signed;
  logic            r_q_neg;
  logic            r_r_neg;
  logic            r_dzero;
  logic            r_ovf;
  logic            r_out_valid;
  logic [XLEN-1:0] r_quotient;
  logic [XLEN-1:0] r_remainder;

  // Operand magnitudes taken straight from the inputs on the accept edge.
  logic            w_in_dvd_neg;
  logic            w_in_dsr_neg;
  logic [XLEN-1:0] w_in_dvd_mag;
  logic [XLEN-1:0] w_in_dsr_mag;
  logic            w_accept;

  assign w_in_dvd_neg = div_signed & dividend[XLEN-1];
  assign w_in_dsr_neg = div_signed & divisor[XLEN-1];
  assign w_in_dvd_mag = w_in_dvd_neg ? (~dividend + 1'b1) : dividend;
  assign w_in_dsr_mag = w_in_dsr_neg ? (~divisor + 1'b1) : divisor;
  assign w_accept     = div_valid && (r_state == S_IDLE) && !flush;

`ifdef DIV_EARLY_OUT_EN
  logic w_early_zero;
  logic w_early_ovf;
  logic w_early_small;
  assign w_early_zero  = (divisor == '0);
  assign w_early_ovf   = div_signed && (dividend == XMIN) && (divisor == '1);
  assign w_early_small = (w_in_dvd_mag < w_in_dsr_mag);
`endif

  // One restoring step. The partial remainder is always below the divisor
  // magnitude, so a one-bit-wider shift value plus a borrow bit is enough.
  logic [XLEN:0]   w_shift;
  logic [XLEN+1:0] w_diff;
  logic            w_neg;
  logic [XLEN-1:0] w_rem_step;
  logic [XLEN-1:0] w_quo_step;

  assign w_shift    = {r_rem, r_quo[XLEN-1]};
  assign w_diff     = {1'b0, w_shift} - {2'b00, r_dsr_mag};
  assign w_neg      = w_diff[XLEN+1];
  assign w_rem_step = w_neg ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
  assign w_quo_step = {r_quo[XLEN-2:0], ~w_neg};

  // Final sign correction with special-case substitution.
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;

  always_comb begin
    w_q_fix = (r_signed && r_q_neg) ? (~r_quo + 1'b1) : r_quo;
    w_r_fix = (r_signed && r_r_neg) ? (~r_rem + 1'b1) : r_rem;
    if (r_dzero) begin
      w_q_fix = '1;
      w_r_fix = r_dvd_raw;
    end else if (r_ovf) begin
      w_q_fix = r_dvd_raw;
      w_r_fix = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_fin       <= 1'b0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dsr_mag   <= '0;
      r_dvd_raw   <= '0;
      r_signed    <= 1'b0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_dzero     <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_fin       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rem     <= '0;
            r_quo     <= w_in_dvd_mag;
            r_dsr_mag <= w_in_dsr_mag;
            r_dvd_raw <= dividend;
            r_signed  <= div_signed;
            r_q_neg   <= w_in_dvd_neg ^ w_in_dsr_neg;
            r_r_neg   <= w_in_dvd_neg;
            r_dzero   <= (divisor == '0);
            r_ovf     <= div_signed && (dividend == XMIN) && (divisor == '1);
            r_cnt     <= '0;
            r_fin     <= 1'b0;
            r_state   <= S_CALC;
`ifdef DIV_EARLY_OUT_EN
            if (w_early_zero) begin
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else if (w_early_ovf) begin
              r_quotient  <= dividend;
              r_remainder <= '0;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else if (w_early_small) begin
              r_quotient  <= '0;
              r_remainder <= dividend;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
`endif
          end
        end
        S_CALC: begin
          if (r_fin) begin
            r_quotient  <= w_q_fix;
            r_remainder <= w_r_fix;
            r_out_valid <= 1'b1;
            r_fin       <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_rem <= w_rem_step;
            r_quo <= w_quo_step;
            if (r_cnt == CW'(XLEN-1)) begin
              r_cnt <= '0;
              r_fin <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign div_ready = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

endmodule

// File: tb/tb_div_iter.sv
// ----------------------------------------------------------------------------
// tb_div_iter -- directed testbench for div_iter with hand-computed results.
// ----------------------------------------------------------------------------
module tb_div_iter;

  localparam int XLEN = 64;
  localparam int FULL_LAT = XLEN + 1;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            div_valid;
  logic            div_ready;
  logic            div_signed;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  int checks;
  int failures;

  div_iter #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h want 0x%016h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%016h", tag, got);
    end
  endtask

  function automatic int exp_lat(input bit early_case);
    return (EARLY && early_case) ? 0 : FULL_LAT;
  endfunction

  // Drive a request, take the accept edge, then scramble the operand inputs.
  task automatic start_op(input bit s, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    div_valid  = 1'b1;
    div_signed = s;
    dividend   = a;
    divisor    = b;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    dividend  = 64'hDEAD_BEEF_0BAD_F00D;
    divisor   = 64'h0000_0000_0000_0003;
    div_signed = ~s;
  endtask

  // Wait (bounded) for out_valid, counting edges after the accept edge.
  task automatic finish_op(input string tag, input logic [63:0] eq, input logic [63:0] er,
                           input int elat, input bit handshake);
    int lat;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    if (handshake) begin
      @(posedge clk);
      #1;
      chk({tag, "_vdrop"}, 64'(out_valid), 64'd0);
      chk({tag, "_rdy"}, 64'(div_ready), 64'd1);
    end
  endtask

  initial begin
    bit seen;
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    div_valid  = 1'b0;
    div_signed = 1'b0;
    dividend   = '0;
    divisor    = '0;
    out_ready  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(div_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_q", quotient, 64'd0);
    chk("rst_r", remainder, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Main function
    start_op(1'b0, 64'd100, 64'd7);
    finish_op("u100d7", 64'd14, 64'd2, exp_lat(1'b0), 1'b1);
    start_op(1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);
    finish_op("sm100d7", 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, exp_lat(1'b0), 1'b1);
    start_op(1'b1, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9);
    finish_op("s100dm7", 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, exp_lat(1'b0), 1'b1);
    start_op(1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    finish_op("sm7d2", 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, exp_lat(1'b0), 1'b1);
    start_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    finish_op("umaxd2", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, exp_lat(1'b0), 1'b1);

    // Special and small cases
    start_op(1'b0, 64'h1234, 64'd0);
    finish_op("udz", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, exp_lat(1'b1), 1'b1);
    start_op(1'b1, 64'h1234, 64'd0);
    finish_op("sdz", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, exp_lat(1'b1), 1'b1);
    start_op(1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    finish_op("sovf", 64'h8000_0000_0000_0000, 64'd0, exp_lat(1'b1), 1'b1);
    start_op(1'b0, 64'd5, 64'd9);
    finish_op("u5d9", 64'd0, 64'd5, exp_lat(1'b1), 1'b1);
    start_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5);
    finish_op("sm3d5", 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, exp_lat(1'b1), 1'b1);

    // Flush at iteration 30 with a simultaneous request that must be refused
    start_op(1'b0, 64'd1000, 64'd3);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    @(negedge clk);
    flush      = 1'b1;
    div_valid  = 1'b1;
    div_signed = 1'b0;
    dividend   = 64'd77;
    divisor    = 64'd7;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    div_valid = 1'b0;
    chk("flush_rdy", 64'(div_ready), 64'd1);
    chk("flush_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush_noresult", 64'(seen), 64'd0);
    start_op(1'b0, 64'd50, 64'd5);
    finish_op("u50d5", 64'd10, 64'd0, exp_lat(1'b0), 1'b1);

    // Hold in DONE with out_ready low while inputs wiggle
    out_ready = 1'b0;
    start_op(1'b0, 64'd1000, 64'd7);
    finish_op("hold", 64'd142, 64'd6, exp_lat(1'b0), 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      div_valid  = 1'b1;
      div_signed = 1'(i);
      dividend   = {$urandom, $urandom};
      divisor    = {$urandom, $urandom};
      @(posedge clk);
      #1;
      chk("hold_q", quotient, 64'd142);
      chk("hold_r", remainder, 64'd6);
      chk("hold_v", 64'(out_valid), 64'd1);
      chk("hold_rdy", 64'(div_ready), 64'd0);
    end
    @(negedge clk);
    div_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("pulse_vdrop", 64'(out_valid), 64'd0);
    chk("pulse_rdy", 64'(div_ready), 64'd1);

    // Flush in DONE without out_ready drops the result
    start_op(1'b0, 64'd81, 64'd9);
    finish_op("dflush", 64'd9, 64'd0, exp_lat(1'b0), 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("dflush_valid", 64'(out_valid), 64'd0);
    chk("dflush_rdy", 64'(div_ready), 64'd1);
    out_ready = 1'b1;

    // Asynchronous reset in the middle of CALC
    start_op(1'b0, 64'd1000, 64'd7);
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_rdy", 64'(div_ready), 64'd1);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_q", quotient, 64'd0);
    chk("arst_r", remainder, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(1'b0, 64'd9, 64'd3);
    finish_op("post_rst", 64'd3, 64'd0, exp_lat(1'b0), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
